// File: rtl/axis_nibble_pkg.sv
// Shared types and nibble/keep helpers for the AXI-Stream nibble unpacker.
package axis_nibble_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned NW       = 4;
    localparam int unsigned BUF_NIB  = 8;

    // Bit-count keep to nibble count; keep[1:0] ignored, values above 16 clamp to 4.
    function automatic logic [2:0] keep_to_nib(input logic [7:0] keep);
        if (keep >= 8'd16)
            return 3'd4;
        return {1'b0, keep[3:2]};
    endfunction

    function automatic logic [7:0] nib_to_keep(input logic [2:0] n);
        return {3'b000, n, 2'b00};
    endfunction

    function automatic logic [15:0] nib_mask(input logic [2:0] n);
        case (n)
            3'd0:    return 16'h0000;
            3'd1:    return 16'h000F;
            3'd2:    return 16'h00FF;
            3'd3:    return 16'h0FFF;
            default: return 16'hFFFF;
        endcase
    endfunction

endpackage

// File: rtl/nibble_shift_buf.sv
// 8-nibble LSB-first buffer with a count; shift-out is applied before append.
module nibble_shift_buf
    import axis_nibble_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic [2:0]  shift_n,
    input  logic        append_en,
    input  logic [2:0]  append_n,
    input  logic [15:0] append_data,
    output logic [31:0] nib_buf,
    output logic [3:0]  count
);

    logic [31:0] buf_q, buf_d, shifted, ins;
    logic [3:0]  count_q, count_d, cnt_s;

    always_comb begin
        shifted = buf_q >> {shift_n, 2'b00};
        cnt_s   = count_q - {1'b0, shift_n};
        ins     = {16'h0000, append_data & nib_mask(append_n)} << {cnt_s, 2'b00};
        buf_d   = shifted;
        count_d = cnt_s;
        if (append_en) begin
            buf_d   = shifted | ins;
            count_d = cnt_s + {1'b0, append_n};
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign nib_buf = buf_q;
    assign count   = count_q;

endmodule

// File: rtl/axis_nibble_unpacker.sv
// AXI-Stream width-down unpacker: packed 16-bit words to 1..4 nibble beats.
// Optional sticky keep-error flag when AXIS_UNPACK_ERR_EN is defined.
module axis_nibble_unpacker #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [2:0]            cfg_nibbles,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [7:0]            s_axis_tkeep,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [7:0]            m_axis_tkeep
`ifdef AXIS_UNPACK_ERR_EN
    ,
    output logic                  err_tkeep
`endif
);
    import axis_nibble_pkg::*;

    state_t      state_q, state_d;
    logic [2:0]  cfg_q, cfg_in;
    logic        tready_q;
    logic [31:0] nib_buf;
    logic [3:0]  count, count_d;
    logic [2:0]  out_n, in_n, shift_n;
    logic        s_accept, m_fire, last_beat;

    always_comb begin
        cfg_in        = (cfg_nibbles == 3'd0 || cfg_nibbles > 3'd4) ? 3'd4 : cfg_nibbles;
        out_n         = (count < {1'b0, cfg_q}) ? count[2:0] : cfg_q;
        in_n          = keep_to_nib(s_axis_tkeep);
        s_accept      = s_axis_tvalid && tready_q;
        m_axis_tvalid = (state_q == RUN && count >= {1'b0, cfg_q}) || (state_q == FLUSH);
        last_beat     = (state_q == FLUSH) && (count <= {1'b0, cfg_q});
        m_fire        = m_axis_tvalid && m_axis_tready;
        shift_n       = m_fire ? out_n : 3'd0;
        count_d       = count - {1'b0, shift_n} + (s_accept ? {1'b0, in_n} : 4'd0);
        m_axis_tdata  = nib_buf[DATA_WIDTH-1:0] & nib_mask(out_n);
        m_axis_tkeep  = nib_to_keep(out_n);
        m_axis_tlast  = last_beat;
        s_axis_tready = tready_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_accept) state_d = s_axis_tlast ? FLUSH : RUN;
            RUN:     if (s_accept && s_axis_tlast) state_d = FLUSH;
            FLUSH:   if (m_fire && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered from next-state values, so it never depends on m_axis_tready combinationally.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q  <= IDLE;
            cfg_q    <= 3'd4;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= (state_d != FLUSH) && (count_d <= 4'd4);
            if (state_q == IDLE && s_accept)
                cfg_q <= cfg_in;
        end
    end

`ifdef AXIS_UNPACK_ERR_EN
    always_ff @(posedge clk) begin
        if (areset)
            err_tkeep <= 1'b0;
        else if (s_accept && (s_axis_tkeep[1:0] != 2'b00 || s_axis_tkeep > 8'd16 ||
                              (!s_axis_tlast && s_axis_tkeep != 8'd16)))
            err_tkeep <= 1'b1;
    end
`endif

    nibble_shift_buf u_buf (
        .clk         (clk),
        .areset      (areset),
        .shift_n     (shift_n),
        .append_en   (s_accept),
        .append_n    (in_n),
        .append_data (s_axis_tdata[15:0]),
        .nib_buf     (nib_buf),
        .count       (count)
    );

endmodule

// File: tb/tb_axis_nibble_unpacker.sv
// Self-checking bench for axis_nibble_unpacker against a nibble-list packet model.
module tb_axis_nibble_unpacker;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [2:0]  cfg_nibbles = 3'd4;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  s_axis_tkeep = '0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tkeep;
`ifdef AXIS_UNPACK_ERR_EN
    logic        err_tkeep;
`endif

    axis_nibble_unpacker #(.DATA_WIDTH(16)) dut (
        .clk           (clk),
        .areset        (areset),
        .cfg_nibbles   (cfg_nibbles),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tkeep  (s_axis_tkeep),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep)
`ifdef AXIS_UNPACK_ERR_EN
        ,
        .err_tkeep     (err_tkeep)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t pkt[$];
    beat_t in_q[$];
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [15:0] d, input logic [7:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        pkt.push_back(b);
    endtask

    // Model: flatten packet into a nibble list, then cut it into cfg-sized beats.
    task automatic model(input int cfg);
        int    nibs[$];
        int    c, kk, n;
        beat_t e;
        c = (cfg == 0 || cfg > 4) ? 4 : cfg;
        foreach (pkt[i]) begin
            kk = pkt[i].k;
            if (kk > 16) kk = 16;
            for (int j = 0; j < kk / 4; j++)
                nibs.push_back((pkt[i].d >> (4 * j)) & 15);
        end
        if (nibs.size() == 0) begin
            e.d = 0; e.k = 0; e.l = 1;
            exp_q.push_back(e);
        end
        while (nibs.size() > 0) begin
            n = (nibs.size() < c) ? nibs.size() : c;
            e.d = 0;
            for (int j = 0; j < n; j++)
                e.d = e.d + 16'(nibs.pop_front() << (4 * j));
            e.k = 8'(4 * n);
            e.l = (nibs.size() == 0);
            exp_q.push_back(e);
        end
        foreach (pkt[i]) in_q.push_back(pkt[i]);
        pkt.delete();
    endtask

    // rmode: 0 always ready, 1 toggling, 2 random. vrand: random source gaps.
    task automatic run_packet(input int cfg, input int rmode, input bit vrand);
        int          budget;
        bit          first, held, sr_before;
        logic [15:0] h_d;
        logic [7:0]  h_k;
        logic        h_l;
        beat_t       e;
        model(cfg);
        budget = 0; first = 1; held = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
            sr_before = s_axis_tready;
            if (in_q.size() > 0) begin
                s_axis_tvalid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_axis_tdata  = in_q[0].d;
                s_axis_tkeep  = in_q[0].k;
                s_axis_tlast  = in_q[0].l;
            end else begin
                s_axis_tvalid = 1'b0;
            end
            cfg_nibbles   = first ? 3'(cfg) : 3'($urandom_range(0, 7));
            m_axis_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(budget % 2) : 1'($urandom_range(0, 1));
            #1;
            chk("tready_registered", s_axis_tready, sr_before);
            if (held) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, h_d);
                chk("hold_keep", m_axis_tkeep, h_k);
                chk("hold_last", m_axis_tlast, h_l);
            end
            held = 0;
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    chk("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", m_axis_tdata, e.d);
                        chk("out_keep", m_axis_tkeep, e.k);
                        chk("out_last", m_axis_tlast, e.l);
                    end
                end else begin
                    held = 1; h_d = m_axis_tdata; h_k = m_axis_tkeep; h_l = m_axis_tlast;
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                void'(in_q.pop_front());
                first = 0;
            end
            @(posedge clk);
        end
        chk("packet_drained", exp_q.size() + in_q.size(), 0);
        exp_q.delete();
        in_q.delete();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tkeep", m_axis_tkeep, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_sready", s_axis_tready, 0);
`ifdef AXIS_UNPACK_ERR_EN
        chk("rst_err", err_tkeep, 0);
`endif
        areset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("sready_after_rst", s_axis_tready, 1);
    endtask

    initial begin
        do_reset();

        add(16'hABCD, 8'd16, 1'b1);
        run_packet(1, 0, 0);

        add(16'h4321, 8'd16, 1'b0);
        add(16'h0065, 8'd8, 1'b1);
        run_packet(3, 0, 0);

        add(16'h1111, 8'd16, 1'b0);
        add(16'h2222, 8'd16, 1'b0);
        add(16'h3333, 8'd16, 1'b1);
        run_packet(4, 1, 0);

        add(16'h00F7, 8'd12, 1'b1);
        run_packet(2, 0, 0);

        add(16'h0000, 8'd0, 1'b1);
        run_packet(2, 1, 0);

        // Reset after the first of four cfg=1 output beats.
        @(negedge clk);
        cfg_nibbles = 3'd1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'hABCD;
        s_axis_tkeep = 8'd16; s_axis_tlast = 1'b1; m_axis_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        #1;
        chk("abort_first_valid", m_axis_tvalid, 1);
        chk("abort_first_data", m_axis_tdata, 16'h000D);
        m_axis_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        areset = 1'b1; m_axis_tready = 1'b0;
        #1;
        chk("abort_second_data", m_axis_tdata, 16'h000C);
        @(posedge clk);
        @(negedge clk);
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_tkeep", m_axis_tkeep, 0);
        chk("abort_tlast", m_axis_tlast, 0);
        areset = 1'b0;
        @(posedge clk);
        add(16'h0005, 8'd4, 1'b1);
        run_packet(1, 0, 0);

        // Short non-last beat: packed contiguously, flagged when the error port exists.
        add(16'h0021, 8'd8, 1'b0);
        add(16'h0043, 8'd16, 1'b1);
        run_packet(4, 2, 0);
`ifdef AXIS_UNPACK_ERR_EN
        chk("err_set", err_tkeep, 1);
        add(16'h9876, 8'd16, 1'b1);
        run_packet(2, 0, 0);
        chk("err_sticky", err_tkeep, 1);
        do_reset();
`endif

        for (int p = 0; p < 40; p++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++)
                add(16'($urandom), ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                                               : 8'(4 * $urandom_range(0, 4)),
                    w == nw - 1);
            run_packet($urandom_range(0, 7), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
